long_lat_issue_port: RTL and testbench
======================================

LONG_LAT_ISSUE_PORT -- requirements
Module: long_lat_issue_port

Interface
REQ-001 The block SHALL have parameter S2E_LEN, default `PORT_S2E_LEN, meaning the width of the scheduler-to-execute uop bundle.
REQ-002 The block SHALL have parameter KM_W, default `SPEC_STATES, meaning the kill-mask width.
REQ-003 The block SHALL have parameter TIMEOUT, default 200, meaning the number of WAIT cycles before Timeout asserts.
REQ-004 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port Flush  in  1  pipeline flush.
REQ-007 Port Kill_Enable, Kill_VKillMask  in  1, KM_W  branch-mispredict kill.
REQ-008 Port Resolve_Enable, Resolve_Mask  in  1, KM_W  branch resolved correctly; clears the given kill-mask bits.
REQ-009 Port In_Valid, In_S2E  in  1, S2E_LEN  uop offered by scheduler select.
REQ-010 Port In_Ready  out  1  port can accept a uop this cycle.
REQ-011 Port Port_Valid, Port_S2E  out  1, S2E_LEN  issue to the multi-cycle FU (IDIV-class).
REQ-012 Port FU_Ready  in  1  FU idle and able to start.
REQ-013 Port FU_Done  in  1  WAKEUP_RESP_VALID bit of the FU wakeup response.
REQ-014 Port Busy, Timeout  out  1, 1  port occupied; WAIT exceeded TIMEOUT.

Function
REQ-015 The block SHALL hold two entries, H (active, driven on Port_S2E) and Q (pending), each a valid bit plus an S2E bundle.
REQ-016 The FSM SHALL have states IDLE (H empty), ISSUE (H valid, not yet accepted by the FU) and WAIT (H accepted, result outstanding).
REQ-017 Port_Valid SHALL equal (state==ISSUE) & FU_Ready & ~kill_H & ~Flush.
REQ-018 Port_Valid & FU_Ready SHALL move ISSUE->WAIT on the next edge.
REQ-019 FU_Done in WAIT SHALL free H; if Q is valid, Q SHALL move to H and the state go to ISSUE, else the state SHALL go to IDLE.
REQ-020 Port_S2E SHALL equal H's bundle, held stable from ISSUE through the FU_Done cycle, because the FU samples destination fields at completion; Port_S2E SHALL be 0 in IDLE.
REQ-021 In_Ready SHALL equal ~Q.valid; In_Valid & In_Ready SHALL load H when H is empty or freed this cycle, else load Q.
REQ-022 Minimum latency SHALL be: uop accepted in cycle N into an empty port with FU_Ready=1 gives Port_Valid=1 in cycle N+1.
REQ-023 kill_X SHALL equal Kill_Enable & |(X.killmask & Kill_VKillMask) for X in {H, Q, In}; a killed entry SHALL be invalidated and a killed incoming uop dropped.
REQ-024 A kill on H in ISSUE or WAIT SHALL return the state to IDLE, or to ISSUE with Q promoted if Q survives; the block SHALL issue no flush to the FU, which kills itself from the same kill inputs.
REQ-025 Kill and FU_Done in the same cycle SHALL be treated as a kill.
REQ-026 Resolve_Enable SHALL clear Resolve_Mask bits in the H, Q and incoming killmasks, applied before the kill comparison in the same cycle.
REQ-027 Flush SHALL invalidate H and Q, force IDLE, and hold Port_Valid=0 that cycle.
REQ-028 Busy SHALL equal H.valid.
REQ-029 A 16-bit saturating counter SHALL count cycles in WAIT and clear on leaving WAIT.
REQ-030 Timeout SHALL be high while the WAIT counter is >= TIMEOUT.

Reset
REQ-031 On rst_n low (asynchronous): state=IDLE, H.valid=Q.valid=0, bundles and counter=0.
REQ-032 Outputs during and after reset SHALL be Port_Valid=0, Port_S2E=0, In_Ready=1, Busy=0, Timeout=0.
REQ-033 Reset mid-WAIT SHALL discard the outstanding uop without issuing any further Port_Valid.

Structure
REQ-034 The FSM state enum, S2E field offsets (KILLMASK slice) and the TIMEOUT default SHALL live in the shared core package/defines.
REQ-035 The H and Q holding-entry register with kill and resolve mask update SHALL be one sub-module, issue_entry, instantiated twice.

Verification
REQ-036 Directed scenario: single uop, FU_Ready=1, FU_Done 34 cycles after issue -> Port_Valid 1 cycle at N+1, Busy high 35 cycles, then IDLE and In_Ready=1.
REQ-037 Directed scenario: two back-to-back uops -> second held in Q, In_Ready=0; Port_Valid for the second 1 cycle after the first's FU_Done.
REQ-038 Directed scenario: kill mask 4'b0010 on H in WAIT with Q mask 4'b0100 -> H dropped, Q issued next cycle, no Port_Valid for H.
REQ-039 Directed scenario: Resolve_Mask=4'b0010 and Kill_VKillMask=4'b0010 in the same cycle -> entry survives.
REQ-040 Directed scenario: FU_Done and kill in the same cycle -> entry freed as killed, state IDLE.
REQ-041 Directed scenario: FU_Done withheld -> Timeout rises after exactly TIMEOUT WAIT cycles; rst_n pulse mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/long_lat_issue_port_pkg.sv
// Shared definitions for the long-latency issue port: FSM states, bundle field
// offsets and default sizing.
package long_lat_issue_port_pkg;

    localparam int PORT_S2E_LEN = 32;
    localparam int SPEC_STATES  = 4;
    localparam int KILLMASK_LSB = 0;
    localparam int TIMEOUT_DEF  = 200;
    localparam int WAIT_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } port_state_e;

endpackage

// File: rtl/long_lat_issue_port_if.sv
// Scheduler-select and FU handshake bundle for the long-latency issue port.
interface long_lat_issue_port_if
    import long_lat_issue_port_pkg::*;
#(
    parameter int S2E_LEN = PORT_S2E_LEN
);
    logic               In_Valid;
    logic [S2E_LEN-1:0] In_S2E;
    logic               In_Ready;
    logic               Port_Valid;
    logic [S2E_LEN-1:0] Port_S2E;
    logic               FU_Ready;
    logic               FU_Done;

    modport slave (
        input  In_Valid, In_S2E, FU_Ready, FU_Done,
        output In_Ready, Port_Valid, Port_S2E
    );

    modport master (
        output In_Valid, In_S2E, FU_Ready, FU_Done,
        input  In_Ready, Port_Valid, Port_S2E
    );
endinterface

// File: rtl/long_lat_issue_port_issue_entry.sv
// One holding entry (valid + uop bundle) that tracks branch resolve and kill
// against the killmask field of its stored bundle.
module issue_entry
    import long_lat_issue_port_pkg::*;
#(
    parameter int S2E_LEN = PORT_S2E_LEN,
    parameter int KM_W    = SPEC_STATES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_kill_en,
    input  logic [KM_W-1:0]    i_kill_mask,
    input  logic               i_res_en,
    input  logic [KM_W-1:0]    i_res_mask,
    input  logic               i_load,
    input  logic [S2E_LEN-1:0] i_load_s2e,
    input  logic               i_free,
    output logic               o_valid,
    output logic [S2E_LEN-1:0] o_s2e,
    output logic               o_kill
);

    logic               r_valid;
    logic [S2E_LEN-1:0] r_s2e;
    logic [KM_W-1:0]    w_km_res;
    logic [S2E_LEN-1:0] w_s2e_res;

    // Resolve clears mask bits before the kill compare in the same cycle.
    always_comb begin
        w_km_res = r_s2e[KILLMASK_LSB +: KM_W];
        if (i_res_en) begin
            w_km_res = w_km_res & ~i_res_mask;
        end
        w_s2e_res = r_s2e;
        w_s2e_res[KILLMASK_LSB +: KM_W] = w_km_res;
    end

    assign o_kill  = r_valid & i_kill_en & (|(w_km_res & i_kill_mask));
    assign o_valid = r_valid;
    assign o_s2e   = r_s2e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_s2e   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_s2e   <= i_load_s2e;
        end else if (o_kill || i_free) begin
            r_valid <= 1'b0;
        end else begin
            r_s2e   <= w_s2e_res;
        end
    end

endmodule

// File: rtl/long_lat_issue_port.sv
// Two-entry issue port feeding a multi-cycle (IDIV-class) FU: H is in flight,
// Q waits behind it; H is held on Port_S2E until the FU reports completion.
module long_lat_issue_port
    import long_lat_issue_port_pkg::*;
#(
    parameter int S2E_LEN = PORT_S2E_LEN,
    parameter int KM_W    = SPEC_STATES,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Flush,
    input  logic                   Kill_Enable,
    input  logic [KM_W-1:0]        Kill_VKillMask,
    input  logic                   Resolve_Enable,
    input  logic [KM_W-1:0]        Resolve_Mask,
    long_lat_issue_port_if.slave   bus,
    output logic                   Busy,
    output logic                   Timeout
);

    function automatic logic [S2E_LEN-1:0] f_resolve(
        input logic [S2E_LEN-1:0] s2e,
        input logic               en,
        input logic [KM_W-1:0]    mask
    );
        logic [S2E_LEN-1:0] v;
        v = s2e;
        if (en) begin
            v[KILLMASK_LSB +: KM_W] = s2e[KILLMASK_LSB +: KM_W] & ~mask;
        end
        return v;
    endfunction

    function automatic logic [WAIT_CNT_W-1:0] f_sat_inc(input logic [WAIT_CNT_W-1:0] v);
        return (&v) ? v : v + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    port_state_e             r_state;
    port_state_e             w_state_nxt;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;

    logic                    w_h_valid, w_q_valid;
    logic                    w_h_kill, w_q_kill;
    logic [S2E_LEN-1:0]      w_h_s2e, w_q_s2e;
    logic [S2E_LEN-1:0]      w_in_s2e_res, w_q_s2e_res, w_h_load_s2e;
    logic                    w_in_kill, w_in_ready, w_accept;
    logic                    w_fu_done, w_h_free, w_h_open, w_q_surv;
    logic                    w_promote, w_h_load, w_q_load, w_issue;

    assign w_in_s2e_res = f_resolve(bus.In_S2E, Resolve_Enable, Resolve_Mask);
    assign w_q_s2e_res  = f_resolve(w_q_s2e, Resolve_Enable, Resolve_Mask);
    assign w_in_kill    = Kill_Enable & (|(w_in_s2e_res[KILLMASK_LSB +: KM_W] & Kill_VKillMask));

    assign w_in_ready = ~w_q_valid;
    assign w_accept   = bus.In_Valid & w_in_ready & ~w_in_kill & ~Flush;

    // A kill in the completion cycle takes the same path as a plain free.
    assign w_fu_done  = (r_state == ST_WAIT) & bus.FU_Done;
    assign w_h_free   = w_fu_done | w_h_kill;
    assign w_h_open   = ~w_h_valid | w_h_free;
    assign w_q_surv   = w_q_valid & ~w_q_kill;

    assign w_promote    = w_h_open & w_q_surv;
    assign w_h_load     = w_h_open & (w_q_surv | w_accept);
    assign w_h_load_s2e = w_q_surv ? w_q_s2e_res : w_in_s2e_res;
    assign w_q_load     = ~w_h_open & w_accept;

    assign w_issue = (r_state == ST_ISSUE) & bus.FU_Ready & ~w_h_kill & ~Flush;

    issue_entry #(
        .S2E_LEN (S2E_LEN),
        .KM_W    (KM_W)
    ) u_h (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (Flush),
        .i_kill_en   (Kill_Enable),
        .i_kill_mask (Kill_VKillMask),
        .i_res_en    (Resolve_Enable),
        .i_res_mask  (Resolve_Mask),
        .i_load      (w_h_load),
        .i_load_s2e  (w_h_load_s2e),
        .i_free      (w_h_free),
        .o_valid     (w_h_valid),
        .o_s2e       (w_h_s2e),
        .o_kill      (w_h_kill)
    );

    issue_entry #(
        .S2E_LEN (S2E_LEN),
        .KM_W    (KM_W)
    ) u_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (Flush),
        .i_kill_en   (Kill_Enable),
        .i_kill_mask (Kill_VKillMask),
        .i_res_en    (Resolve_Enable),
        .i_res_mask  (Resolve_Mask),
        .i_load      (w_q_load),
        .i_load_s2e  (w_in_s2e_res),
        .i_free      (w_promote),
        .o_valid     (w_q_valid),
        .o_s2e       (w_q_s2e),
        .o_kill      (w_q_kill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (Flush) begin
            w_state_nxt = ST_IDLE;
        end else if (w_h_load) begin
            w_state_nxt = ST_ISSUE;
        end else if (w_h_free) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_ISSUE: if (w_issue) w_state_nxt = ST_WAIT;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        bus.Port_Valid = w_issue;
        bus.Port_S2E   = (r_state != ST_IDLE) ? w_h_s2e : '0;
        bus.In_Ready   = w_in_ready;
        Busy           = w_h_valid;
        Timeout        = (r_wait_cnt >= WAIT_CNT_W'(TIMEOUT));
    end

    // Counts only while staying in WAIT so Timeout drops the cycle WAIT is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT && w_state_nxt == ST_WAIT) begin
            r_wait_cnt <= f_sat_inc(r_wait_cnt);
        end else begin
            r_wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_long_lat_issue_port.sv
// Directed bench for long_lat_issue_port: stimulus queues expected issues and
// status values; a negedge monitor pops and compares them.
module tb_long_lat_issue_port;
    import long_lat_issue_port_pkg::*;

    localparam int S2E_LEN = 32;
    localparam int KM_W    = 4;
    localparam int TMO     = 200;

    localparam int K_BUSY  = 0;
    localparam int K_INRDY = 1;
    localparam int K_TMO   = 2;
    localparam int K_S2E   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            Flush = 1'b0;
    logic            Kill_Enable = 1'b0;
    logic [KM_W-1:0] Kill_VKillMask = '0;
    logic            Resolve_Enable = 1'b0;
    logic [KM_W-1:0] Resolve_Mask = '0;
    logic            Busy, Timeout;

    long_lat_issue_port_if #(.S2E_LEN(S2E_LEN)) bus();

    long_lat_issue_port #(
        .S2E_LEN (S2E_LEN),
        .KM_W    (KM_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Flush          (Flush),
        .Kill_Enable    (Kill_Enable),
        .Kill_VKillMask (Kill_VKillMask),
        .Resolve_Enable (Resolve_Enable),
        .Resolve_Mask   (Resolve_Mask),
        .bus            (bus),
        .Busy           (Busy),
        .Timeout        (Timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int kind; logic [31:0] exp;} chk_t;
    typedef struct {int cyc; logic [31:0] s2e;} iss_t;
    chk_t chkq[$];
    iss_t issq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [31:0] act_of(input int k);
        case (k)
            K_BUSY:  return {31'b0, Busy};
            K_INRDY: return {31'b0, bus.In_Ready};
            K_TMO:   return {31'b0, Timeout};
            default: return bus.Port_S2E;
        endcase
    endfunction

    function automatic string name_of(input int k);
        case (k)
            K_BUSY:  return "busy";
            K_INRDY: return "in_ready";
            K_TMO:   return "timeout";
            default: return "port_s2e";
        endcase
    endfunction

    always @(negedge clk) begin
        iss_t        e;
        chk_t        c;
        logic [31:0] a;
        logic        exp_pv;
        while (issq.size() > 0 && issq[0].cyc < cyc) void'(issq.pop_front());
        exp_pv = (issq.size() > 0 && issq[0].cyc == cyc);
        n_chk++;
        if (bus.Port_Valid !== exp_pv) begin
            n_fail++;
            $display("FAIL port_valid: got %b, required %b (cycle %0d)", bus.Port_Valid, exp_pv, cyc);
        end
        if (exp_pv) begin
            e = issq.pop_front();
            n_chk++;
            if (bus.Port_S2E !== e.s2e) begin
                n_fail++;
                $display("FAIL issue_s2e: got %h, required %h (cycle %0d)", bus.Port_S2E, e.s2e, cyc);
            end
        end
        while (chkq.size() > 0 && chkq[0].cyc <= cyc) begin
            c = chkq.pop_front();
            a = act_of(c.kind);
            n_chk++;
            if (a !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h (cycle %0d)", name_of(c.kind), a, c.exp, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int k, input logic [31:0] v);
        chk_t c;
        c.cyc  = cyc;
        c.kind = k;
        c.exp  = v;
        chkq.push_back(c);
    endtask

    task automatic exp_issue(input int at, input logic [31:0] s);
        iss_t e;
        e.cyc = at;
        e.s2e = s;
        issq.push_back(e);
    endtask

    task automatic offer(input logic [31:0] s);
        bus.In_Valid = 1'b1;
        bus.In_S2E   = s;
    endtask

    task automatic expect_idle();
        expect_now(K_BUSY, 0);
        expect_now(K_INRDY, 1);
        expect_now(K_S2E, 0);
        expect_now(K_TMO, 0);
    endtask

    initial begin
        int t;
        bus.In_Valid = 1'b0;
        bus.In_S2E   = '0;
        bus.FU_Ready = 1'b1;
        bus.FU_Done  = 1'b0;

        // reset values while rst_n is held low
        tick(); tick();
        expect_idle();
        tick();
        rst_n = 1'b1;
        tick();
        expect_idle();
        tick();

        // single uop, FU_Done 34 cycles after issue
        t = cyc;
        offer(32'h1111_0001);
        exp_issue(t + 1, 32'h1111_0001);
        expect_now(K_INRDY, 1);
        tick();
        bus.In_Valid = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            expect_now(K_BUSY, 1);
            expect_now(K_S2E, 32'h1111_0001);
            bus.FU_Done = (k == 34);
            tick();
        end
        bus.FU_Done = 1'b0;
        expect_idle();
        tick();

        // back-to-back: second uop parks in Q
        t = cyc;
        offer(32'h2222_0001);
        exp_issue(t + 1, 32'h2222_0001);
        exp_issue(t + 5, 32'h3333_0001);
        tick();
        offer(32'h3333_0001);
        expect_now(K_INRDY, 1);
        tick();
        bus.In_Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_now(K_INRDY, 0);
            expect_now(K_BUSY, 1);
            expect_now(K_S2E, 32'h2222_0001);
            bus.FU_Done = (k == 2);
            tick();
        end
        bus.FU_Done = 1'b0;
        expect_now(K_INRDY, 1);
        expect_now(K_S2E, 32'h3333_0001);
        tick(); tick();
        bus.FU_Done = 1'b1;
        tick();
        bus.FU_Done = 1'b0;
        expect_idle();
        tick();

        // kill H (mask 0010) in WAIT, Q (mask 0100) survives and issues
        t = cyc;
        offer(32'h4444_0002);
        exp_issue(t + 1, 32'h4444_0002);
        exp_issue(t + 4, 32'h5555_0004);
        tick();
        offer(32'h5555_0004);
        tick();
        bus.In_Valid = 1'b0;
        tick();
        Kill_Enable = 1'b1;
        Kill_VKillMask = 4'b0010;
        tick();
        Kill_Enable = 1'b0;
        Kill_VKillMask = '0;
        expect_now(K_BUSY, 1);
        expect_now(K_INRDY, 1);
        expect_now(K_S2E, 32'h5555_0004);
        tick(); tick();
        bus.FU_Done = 1'b1;
        tick();
        bus.FU_Done = 1'b0;
        expect_idle();
        tick();

        // kill while in ISSUE: no Port_Valid
        offer(32'h6666_0008);
        tick();
        bus.In_Valid = 1'b0;
        Kill_Enable = 1'b1;
        Kill_VKillMask = 4'b1000;
        expect_now(K_BUSY, 1);
        tick();
        Kill_Enable = 1'b0;
        Kill_VKillMask = '0;
        expect_idle();
        tick();

        // flush in ISSUE holds Port_Valid low
        offer(32'h7777_0001);
        tick();
        bus.In_Valid = 1'b0;
        Flush = 1'b1;
        expect_now(K_BUSY, 1);
        tick();
        Flush = 1'b0;
        expect_idle();
        tick();

        // flush in WAIT with Q occupied
        t = cyc;
        offer(32'h7878_0001);
        exp_issue(t + 1, 32'h7878_0001);
        tick();
        offer(32'h7979_0001);
        tick();
        bus.In_Valid = 1'b0;
        Flush = 1'b1;
        expect_now(K_INRDY, 0);
        tick();
        Flush = 1'b0;
        expect_idle();
        tick(); tick(); tick();

        // resolve and kill on the same bit in the same cycle: H survives
        t = cyc;
        offer(32'h8888_0002);
        exp_issue(t + 1, 32'h8888_0002);
        tick();
        bus.In_Valid = 1'b0;
        tick();
        Resolve_Enable = 1'b1;
        Resolve_Mask = 4'b0010;
        Kill_Enable = 1'b1;
        Kill_VKillMask = 4'b0010;
        tick();
        Resolve_Enable = 1'b0;
        Resolve_Mask = '0;
        expect_now(K_BUSY, 1);
        tick();
        Kill_Enable = 1'b0;
        Kill_VKillMask = '0;
        expect_now(K_BUSY, 1);
        bus.FU_Done = 1'b1;
        tick();
        bus.FU_Done = 1'b0;
        expect_idle();
        tick();

        // killed incoming uop is dropped
        offer(32'h9999_0004);
        Kill_Enable = 1'b1;
        Kill_VKillMask = 4'b0100;
        tick();
        bus.In_Valid = 1'b0;
        Kill_Enable = 1'b0;
        Kill_VKillMask = '0;
        expect_idle();
        tick();

        // incoming uop resolved and killed on the same bit: accepted, mask cleared
        t = cyc;
        offer(32'hCCCC_0002);
        Resolve_Enable = 1'b1;
        Resolve_Mask = 4'b0010;
        Kill_Enable = 1'b1;
        Kill_VKillMask = 4'b0010;
        exp_issue(t + 1, 32'hCCCC_0000);
        tick();
        bus.In_Valid = 1'b0;
        Resolve_Enable = 1'b0;
        Resolve_Mask = '0;
        Kill_Enable = 1'b0;
        Kill_VKillMask = '0;
        tick();
        bus.FU_Done = 1'b1;
        tick();
        bus.FU_Done = 1'b0;
        expect_idle();
        tick();

        // FU_Done and kill in the same cycle
        t = cyc;
        offer(32'hAAAA_0001);
        exp_issue(t + 1, 32'hAAAA_0001);
        tick();
        bus.In_Valid = 1'b0;
        tick();
        bus.FU_Done = 1'b1;
        Kill_Enable = 1'b1;
        Kill_VKillMask = 4'b0001;
        expect_now(K_BUSY, 1);
        tick();
        bus.FU_Done = 1'b0;
        Kill_Enable = 1'b0;
        Kill_VKillMask = '0;
        expect_idle();
        tick();

        // FU not ready: issue waits for FU_Ready
        t = cyc;
        bus.FU_Ready = 1'b0;
        offer(32'hDDDD_0001);
        exp_issue(t + 2, 32'hDDDD_0001);
        tick();
        bus.In_Valid = 1'b0;
        expect_now(K_BUSY, 1);
        tick();
        bus.FU_Ready = 1'b1;
        tick();
        bus.FU_Done = 1'b1;
        tick();
        bus.FU_Done = 1'b0;
        expect_idle();
        tick();

        // FU_Done withheld: Timeout after TMO WAIT cycles, then reset mid-WAIT
        t = cyc;
        offer(32'hBBBB_0001);
        exp_issue(t + 1, 32'hBBBB_0001);
        tick();
        bus.In_Valid = 1'b0;
        for (int k = 1; k <= TMO + 1; k++) begin
            if (k == TMO + 1) expect_now(K_TMO, 0);
            tick();
        end
        expect_now(K_TMO, 1);
        expect_now(K_BUSY, 1);
        tick();
        expect_now(K_TMO, 1);
        tick();
        rst_n = 1'b0;
        expect_idle();
        tick();
        rst_n = 1'b1;
        tick();
        expect_idle();
        tick(); tick(); tick();
        expect_idle();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
